// File: rtl/imem_prog_loader.sv
// imem_prog_loader: fills instruction memory from a byte stream, holds core.
// Stream: 16-bit LE word count N, then 4N LE payload bytes
//   (plus one XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined).
// Ports: clk, rst_n (sync, active low), start, in_valid/in_data/in_ready,
//   imem_we/imem_addr/imem_wdata, core_hold, done, err.
module imem_prog_loader #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t      state;
   logic [7:0]  n_lo;
   logic [15:0] n_words;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q;
`endif

   logic        xfer;
   logic        restart;
   logic        last_word;
   logic [15:0] n_hdr;
   logic [17:0] word_off;

   assign xfer      = in_valid & in_ready;
   assign n_hdr     = {in_data, n_lo};
   assign last_word = (word_idx == n_words - 16'd1);
   assign word_off  = {word_idx, 2'b00};
   assign restart   = start & ((state == S_IDLE) |
                               (state == S_DONE) |
                               (state == S_ERR));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         core_hold  <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         n_lo       <= '0;
         n_words    <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         asm_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         if (restart) begin
            state     <= S_HDR0;
            in_ready  <= 1'b1;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            word_idx  <= '0;
            byte_idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
         end else begin
            unique case (state)
               S_IDLE: ;
               S_HDR0: begin
                  if (xfer) begin
                     n_lo  <= in_data;
                     state <= S_HDR1;
                  end
               end
               S_HDR1: begin
                  if (xfer) begin
                     n_words <= n_hdr;
                     if (n_hdr == 16'd0) begin
                        state    <= S_DONE;
                        in_ready <= 1'b0;
                     end else if ({1'b0, n_hdr} > MAX_N) begin
                        state    <= S_ERR;
                        in_ready <= 1'b0;
                     end else begin
                        state <= S_LOAD;
                     end
                  end
               end
               S_LOAD: begin
                  if (xfer) begin
                     byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_q   <= csum_q ^ in_data;
`endif
                     unique case (byte_idx)
                        2'd0: asm_q[7:0]   <= in_data;
                        2'd1: asm_q[15:8]  <= in_data;
                        2'd2: asm_q[23:16] <= in_data;
                        default: begin
                           // Fourth byte completes the word; write next cycle.
                           imem_we    <= 1'b1;
                           imem_wdata <= {in_data, asm_q};
                           imem_addr  <= BASE_ADDR + ADDR_W'(word_off);
                           word_idx   <= word_idx + 16'd1;
                           if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                              state    <= S_CSUM;
`else
                              state    <= S_DONE;
                              in_ready <= 1'b0;
`endif
                           end
                        end
                     endcase
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               S_CSUM: begin
                  if (xfer) begin
                     in_ready <= 1'b0;
                     state    <= (in_data == csum_q) ? S_DONE : S_ERR;
                  end
               end
`endif
               S_DONE: begin
                  done      <= 1'b1;
                  core_hold <= 1'b0;
               end
               S_ERR: begin
                  err <= 1'b1;
               end
               default: begin
                  state    <= S_IDLE;
                  in_ready <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_prog_loader.sv
// tb_imem_prog_loader: randomized scoreboard bench for imem_prog_loader.
// Expected writes are queued by a stream-level model; a monitor pops them.
module tb_imem_prog_loader;

   localparam int          ADDR_W = 32;
   localparam int          MAXW   = 4;
   localparam logic [31:0] BASE   = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   imem_prog_loader #(
      .ADDR_W(ADDR_W),
      .BASE_ADDR(BASE),
      .MAX_WORDS(MAXW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .core_hold(core_hold),
      .done(done),
      .err(err)
   );

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  fails  = 0;

   function automatic void chk(input string nm,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Scoreboard monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      wr_t e;
      if (rst_n && imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_write: got addr %h data %h expected none",
                     imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", imem_addr, e.addr);
            chk("wr_data", imem_wdata, e.data);
         end
      end
   end

   // Reference: interpret the byte stream, queue writes, give final outcome.
   function automatic void model(input bq_t s, output bit ed, output bit ee);
      int n;
      logic [7:0] x;
      wr_t e;
      x  = 8'h00;
      ed = 1'b0;
      ee = 1'b0;
      n  = int'({s[1], s[0]});
      if (n == 0) begin
         ed = 1'b1;
      end else if (n > MAXW) begin
         ee = 1'b1;
      end else begin
         for (int w = 0; w < n; w++) begin
            e.addr = BASE + 32'(4 * w);
            e.data = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) x = x ^ s[2+4*w+k];
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (s[2+4*n] == x) ed = 1'b1;
         else ee = 1'b1;
`else
         ed = 1'b1;
`endif
      end
   endfunction

   function automatic bq_t add_csum(input bq_t s, input bit bad);
      int n;
      logic [7:0] x;
      n = int'({s[1], s[0]});
      x = {7'b0, bad};
      for (int i = 2; i < s.size(); i++) x = x ^ s[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (n > 0 && n <= MAXW) s.push_back(x);
`endif
      return s;
   endfunction

   function automatic bq_t rand_prog(input int n);
      bq_t s;
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      if (n <= MAXW)
         for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
      return add_csum(s, $urandom_range(0, 3) == 0);
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: no gaps; 1: toggle valid plus 5-cycle gap; 2: random gaps
   task automatic send(input bq_t s, input int mode);
      int  i;
      int  idle;
      int  gap;
      bit  tog;
      bit  v;
      i = 0; idle = 0; gap = 0; tog = 1'b0;
      while (i < s.size()) begin
         @(negedge clk);
         v = 1'b1;
         if (mode == 1) begin
            if (i == 5 && gap < 5) begin
               v = 1'b0;
               gap++;
            end else begin
               v = ~tog;
               tog = ~tog;
            end
         end else if (mode == 2) begin
            v = ($urandom_range(0, 2) != 0);
         end
         in_valid = v;
         in_data  = s[i];
         if (v && in_ready) begin
            i++;
            idle = 0;
         end else begin
            idle++;
            if (idle > 40) begin
               checks++;
               fails++;
               $display("FAIL send_stall: byte %0d not accepted", i);
               break;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_load(input bq_t s, input int mode);
      bit ed;
      bit ee;
      model(s, ed, ee);
      pulse_start();
      chk("ready_after_start", in_ready, 1);
      send(s, mode);
      chk("ready_after_stream", in_ready, 0);
      chk("hold_on_entry", core_hold, 1);
      chk("done_on_entry", done, 0);
      @(negedge clk);
      chk("done", done, ed);
      chk("err", err, ee);
      chk("core_hold", core_hold, !ed);
      repeat (3) @(negedge clk);
      chk("missing_writes", exp_q.size(), 0);
      chk("done_sticky", done, ed);
      chk("err_sticky", err, ee);
      exp_q.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_imem_we"}, imem_we, 0);
      chk({tag, "_imem_addr"}, imem_addr, BASE);
      chk({tag, "_imem_wdata"}, imem_wdata, 0);
      chk({tag, "_core_hold"}, core_hold, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t s;
      bq_t base_s;
      bit  ed;
      bit  ee;

      base_s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                 8'h93, 8'h00, 8'h20, 8'h00};

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ready_low", in_ready, 0);
      chk("idle_hold_high", core_hold, 1);

      // Two-word program, back-to-back bytes.
      run_load(add_csum(base_s, 1'b0), 0);
      // Same program, toggled valid with a mid-word gap (reload from DONE).
      run_load(add_csum(base_s, 1'b0), 1);
      // Empty program.
      s = '{8'h00, 8'h00};
      run_load(s, 0);
      // Oversize program, then recovery from ERR.
      s = '{8'h05, 8'h00};
      run_load(s, 0);
      run_load(add_csum(base_s, 1'b0), 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h03};
      run_load(s, 0);
      s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h04};
      run_load(s, 0);
`endif

      // Reset after 1.5 words: only word 0 is written.
      model(add_csum(base_s, 1'b0), ed, ee);
      void'(exp_q.pop_back());
      pulse_start();
      s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00};
      send(s, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_vals("midreset");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         chk("ready_low_after_reset", in_ready, 0);
      end
      in_valid = 1'b0;
      chk("midreset_writes", exp_q.size(), 0);
      exp_q.delete();

      for (int it = 0; it < 20; it++) begin
         run_load(rand_prog($urandom_range(0, MAXW + 1)),
                  $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Writer-side counterpart to the simulation observer: it fills instruction memory and holds the 5-stage core in reset state, instead of sampling core state after execution.
- Accepts a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit words, writes them to consecutive word-aligned instruction-memory addresses starting at BASE_ADDR, then releases the core.
- Sits between the test or host byte source and the imem write port / pc reset control of main.

Parameters:
- ADDR_W, 32, width of the imem byte address.
- BASE_ADDR, 0, byte address of the first word written; must be 4-aligned.
- MAX_WORDS, 1024, largest accepted program length in words.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  byte address of the write, 4-aligned.
- imem_wdata  output  32  instruction word.
- core_hold  output  1  high: core held (pc forced to reset value, no fetch).
- done  output  1  sticky; load finished without error.
- err  output  1  sticky; load aborted.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_hold=1, done=0, err=0, all counters 0.
- Transfer rule: a byte transfers only on a posedge with in_valid=1 and in_ready=1. in_ready is registered and depends only on state, never on in_valid. It is 1 in HDR0, HDR1, LOAD and CSUM; 0 elsewhere.
- Stream format: 2-byte little-endian word count N, then 4N payload bytes, each word's LSB first. With CHECKSUM_EN, one checksum byte follows the payload.
- FSM:
  - IDLE: start=1 → HDR0; clear done, err, byte/word counters; core_hold=1. start is ignored in every other state.
  - HDR0: on transfer, latch N[7:0] → HDR1.
  - HDR1: on transfer, latch N[15:8]. Then:
    - N=0 → DONE.
    - N>MAX_WORDS → ERR.
    - otherwise → LOAD.
  - LOAD: shift each transferred byte into a 32-bit assembly register at bits [8*k+7:8*k], k=byte index 0..3.
    - On the 4th byte: next cycle imem_we=1 for exactly one cycle, with imem_wdata=assembled word and imem_addr=BASE_ADDR+4*word_idx. Then word_idx increments.
    - Byte acceptance is not stalled by the write, so back-to-back bytes yield one write every 4 cycles minimum.
    - After word N-1's write is issued → DONE (or CSUM if CHECKSUM_EN).
  - DONE: done=1, core_hold=0 from the cycle after entry. start=1 → HDR0 (reload; core_hold returns to 1 the cycle after).
  - ERR: err=1, core_hold stays 1, no further writes. start=1 → HDR0.
- Idle gaps: in_valid=0 gaps of any length are allowed mid-word and mid-header; the partial word and counters are retained.
- Mid-operation reset: synchronous reset in any state returns to the reset values next edge. A partially loaded memory is not cleared; core_hold=1 guarantees the core does not run it.
- Address arithmetic: word_idx is 16 bits. imem_addr = BASE_ADDR + {word_idx,2'b00}, truncated to ADDR_W. Wrap is unreachable because MAX_WORDS bounds N.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last payload word, the FSM enters CSUM and accepts one byte.
  - The running XOR covers all 4N payload bytes; header bytes are excluded.
  - Match → DONE. Mismatch → ERR. Already-written words remain in imem.
- When undefined:
  - CSUM state and XOR register do not exist.
  - LOAD → DONE directly; no trailing byte is consumed.

Test Plan:
- Reset, then start; stream 02 00 13 00 10 00 93 00 20 00 with no gaps. Expected:
  - exactly two writes: (0x0,0x00100013) and (0x4,0x00200093);
  - done=1, core_hold falls the cycle after DONE;
  - in_ready low outside the load.
- Same stream with in_valid toggling 1/0 every cycle, plus a 5-cycle gap between bytes 2 and 3 of word 0. Expected: identical writes and addresses; no duplicate or missing imem_we.
- Header 00 00. Expected: no imem_we; done=1 two cycles after the second header byte; err=0.
- MAX_WORDS=4, header 05 00. Expected: err=1, done=0, core_hold stays 1, no writes; a later start plus a valid stream succeeds.
- Assert rst_n=0 for one cycle after 1.5 words. Expected:
  - all outputs return to reset values, state IDLE;
  - in_ready=0 until the next start.
- CHECKSUM_EN: one word 13 00 10 00 then checksum 0x03 → done=1. Checksum 0x04 → err=1, core_hold=1, and the word is still written at 0x0.
